// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI transaction sequencer
package spi_pkg;

    localparam int DWIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT,
        STORE,
        HOLD
    } xfer_state_t;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// rtl/spi_xfer_ctrl_if.sv - host byte streams, command and byte-core strobes
interface spi_xfer_ctrl_if #(
    parameter int DWIDTH = 8,
    parameter int LEN_W  = 8
);
    logic [DWIDTH-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DWIDTH-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              ss_n;
    logic              core_cs;
    logic              core_wr;
    logic              core_rd;
    logic [DWIDTH-1:0] core_din;
    logic [DWIDTH-1:0] core_dout;
    logic              core_done;

    // Host plus byte core: drives the command, TX stream and core results.
    modport master (
        output tx_data, tx_valid, rx_ready, start, len, core_dout, core_done,
        input  tx_ready, rx_data, rx_valid, busy, ss_n,
        input  core_cs, core_wr, core_rd, core_din
    );

    // The sequencer itself.
    modport slave (
        input  tx_data, tx_valid, rx_ready, start, len, core_dout, core_done,
        output tx_ready, rx_data, rx_valid, busy, ss_n,
        output core_cs, core_wr, core_rd, core_din
    );
endinterface

// File: rtl/spi_byte_fifo.sv
// rtl/spi_byte_fifo.sv - synchronous first-word-fall-through byte FIFO
module spi_byte_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign do_push   = in_valid & in_ready;
    assign do_pop    = out_valid & out_ready;

    // Storage array; contents are left stale on reset, pointers make them unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - multi-byte SPI transaction sequencer above the byte core
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = 4,
    parameter int LEN_W  = 8,
    parameter int GUARD  = 2
) (
    input logic           clk,
    input logic           rst,
    spi_xfer_ctrl_if.slave bus
);
    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    // The ISSUE cycle itself counts toward the leading guard, so SETUP is one cycle short.
    localparam int SETUP_LAST = (GUARD > 1) ? GUARD - 2 : 0;
    localparam int HOLD_LAST  = GUARD - 1;

    xfer_state_t       state, state_next;
    logic [LEN_W-1:0]  remain, remain_next;
    logic [GW-1:0]     guard_cnt, guard_next;
    logic              done_prev;
    logic              done_edge;
    logic              strobe, strobe_next;
    logic [DWIDTH-1:0] din_q, din_next;
    logic              busy_q;
    logic              ss_q;

    logic [DWIDTH-1:0] tx_head;
    logic              tx_avail;
    logic              tx_pop;
    logic              rx_space;
    logic              rx_push;

    spi_byte_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bus.tx_data),
        .in_valid  (bus.tx_valid),
        .in_ready  (bus.tx_ready),
        .out_data  (tx_head),
        .out_valid (tx_avail),
        .out_ready (tx_pop)
    );

    spi_byte_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bus.core_dout),
        .in_valid  (rx_push),
        .in_ready  (rx_space),
        .out_data  (bus.rx_data),
        .out_valid (bus.rx_valid),
        .out_ready (bus.rx_ready)
    );

    // A done level left over from the previous byte must not count as completion.
    assign done_edge = bus.core_done & ~done_prev;

    assign bus.busy     = busy_q;
    assign bus.ss_n     = ss_q;
    assign bus.core_cs  = strobe;
    assign bus.core_wr  = strobe;
    assign bus.core_rd  = 1'b0;
    assign bus.core_din = din_q;

    // Next-state, counters, FIFO handshakes and next strobe values.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        guard_next  = guard_cnt;
        strobe_next = 1'b0;
        din_next    = din_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && (bus.len != '0)) begin
                    remain_next = bus.len;
                    guard_next  = GW'(SETUP_LAST);
                    state_next  = (GUARD > 1) ? SETUP : ISSUE;
                end
            end
            SETUP: begin
                if (guard_cnt == '0) begin
                    state_next = ISSUE;
                end else begin
                    guard_next = guard_cnt - 1'b1;
                end
            end
            ISSUE: begin
                if (tx_avail) begin
                    tx_pop      = 1'b1;
                    strobe_next = 1'b1;
                    din_next    = tx_head;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                if (done_edge) begin
                    state_next = STORE;
                end
            end
            STORE: begin
                if (rx_space) begin
                    rx_push     = 1'b1;
                    remain_next = remain - 1'b1;
                    if (remain == LEN_W'(1)) begin
                        guard_next = GW'(HOLD_LAST);
                        state_next = HOLD;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            HOLD: begin
                if (guard_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    guard_next = guard_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered outputs; busy/ss_n follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remain    <= '0;
            guard_cnt <= '0;
            done_prev <= 1'b0;
            strobe    <= 1'b0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            ss_q      <= 1'b1;
        end else begin
            state     <= state_next;
            remain    <= remain_next;
            guard_cnt <= guard_next;
            done_prev <= bus.core_done;
            strobe    <= strobe_next;
            din_q     <= din_next;
            busy_q    <= (state_next != IDLE);
            ss_q      <= (state_next == IDLE);
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;
    localparam int DW       = 8;
    localparam int DEPTH    = 4;
    localparam int LEN_W    = 8;
    localparam int GUARD    = 2;
    localparam int XFER     = 4;
    // Cycles from a core_wr pulse to core_done rising in the core model below.
    localparam int DONE_LAT = XFER + 1;
    // Detect -> STORE -> ISSUE -> next core_wr.
    localparam int WR_GAP   = DONE_LAT + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_xfer_ctrl_if #(.DWIDTH(DW), .LEN_W(LEN_W)) bus ();

    spi_xfer_ctrl #(
        .DWIDTH (DW),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W),
        .GUARD  (GUARD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte core model: loopback, done cleared clr_dly cycles after a write.
    logic          m_done   = 1'b0;
    logic [DW-1:0] m_dout   = '0;
    logic [DW-1:0] m_lat    = '0;
    logic          m_active = 1'b0;
    int            m_cyc    = 0;
    int            clr_dly  = 1;
    assign bus.core_done = m_done;
    assign bus.core_dout = m_dout;

    always @(posedge clk) begin
        if (bus.core_wr === 1'b1) begin
            m_lat    <= bus.core_din;
            m_cyc    <= 1;
            m_active <= 1'b1;
        end else if (m_active) begin
            m_cyc <= m_cyc + 1;
            if (m_cyc == clr_dly) m_done <= 1'b0;
            if (m_cyc == XFER) begin
                m_done   <= 1'b1;
                m_dout   <= m_lat;
                m_active <= 1'b0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: core_wr pulses, ss_n edges, cs/wr agreement.
    int            wr_cyc[$];
    logic [DW-1:0] wr_din[$];
    int            fall_cyc = 0;
    int            rise_cyc = 0;
    int            rises    = 0;
    int            cs_bad   = 0;
    logic          prev_ss  = 1'b1;
    always @(negedge clk) begin
        if (bus.core_wr === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_din.push_back(bus.core_din);
        end
        if (bus.core_cs !== bus.core_wr) cs_bad++;
        if (prev_ss === 1'b1 && bus.ss_n === 1'b0) fall_cyc = cyc;
        if (prev_ss === 1'b0 && bus.ss_n === 1'b1) begin
            rise_cyc = cyc;
            rises++;
        end
        prev_ss = bus.ss_n;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int cyc_at(input int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
    endfunction

    function automatic logic [31:0] din_at(input int i);
        return (i < wr_din.size()) ? {24'h0, wr_din[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic clear_log();
        wr_cyc.delete();
        wr_din.delete();
        rises = 0;
    endtask

    task automatic push(input logic [DW-1:0] b, output int p);
        int n = 0;
        while (bus.tx_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("push_ready", bus.tx_ready, 1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        p = cyc;
        step();
        bus.tx_valid = 1'b0;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] l, output int t);
        bus.start = 1'b1;
        bus.len   = l;
        t = cyc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pop_check(input logic [DW-1:0] exp, input string tag, output int q);
        int n = 0;
        while (bus.rx_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, bus.rx_valid, 1);
        chk(tag, bus.rx_data, exp);
        bus.rx_ready = 1'b1;
        q = cyc;
        step();
        bus.rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 400) begin
            step();
            n++;
        end
        chk(tag, bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, p, q, d;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        bus.start    = 1'b0;
        bus.len      = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_ss_n", bus.ss_n, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_core_cs", bus.core_cs, 0);
        chk("rst_core_wr", bus.core_wr, 0);
        chk("rst_core_din", bus.core_din, 0);
        chk("rst_core_rd", bus.core_rd, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_rx_valid", bus.rx_valid, 0);

        // Single byte
        clear_log();
        push(8'hA5, p);
        do_start(8'd1, t);
        chk("t1_busy_next", bus.busy, 1);
        wait_idle("t1_idle");
        chk("t1_wr_count", wr_cyc.size(), 1);
        chk("t1_wr_din", din_at(0), 32'hA5);
        chk("t1_wr_time", cyc_at(0), t + 1 + GUARD);
        chk("t1_ss_fall", fall_cyc, t + 1);
        chk("t1_ss_low", rise_cyc - fall_cyc, GUARD + DONE_LAT + 2 + GUARD);
        pop_check(8'hA5, "t1_rx", q);
        chk("t1_rx_empty", bus.rx_valid, 0);

        // Four bytes, plus a start while busy that must be ignored
        clear_log();
        for (int i = 1; i <= 4; i++) push(DW'(i), p);
        chk("t2_tx_full", bus.tx_ready, 0);
        do_start(8'd4, t);
        repeat (3) step();
        do_start(8'd5, d);
        wait_idle("t2_idle");
        chk("t2_wr_count", wr_cyc.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_din%0d", i), din_at(i), i + 1);
        for (int i = 1; i < 4; i++) chk($sformatf("t2_gap%0d", i), cyc_at(i) - cyc_at(i - 1), WR_GAP);
        chk("t2_ss_rises", rises, 1);
        for (int i = 1; i <= 4; i++) pop_check(DW'(i), $sformatf("t2_rx%0d", i), q);

        // TX underrun
        clear_log();
        push(8'h11, p);
        do_start(8'd3, t);
        repeat (20) step();
        chk("t3_stall_wr", wr_cyc.size(), 1);
        chk("t3_stall_ss_n", bus.ss_n, 0);
        chk("t3_stall_busy", bus.busy, 1);
        push(8'h22, p);
        push(8'h33, d);
        wait_idle("t3_idle");
        chk("t3_wr_count", wr_cyc.size(), 3);
        chk("t3_resume_time", cyc_at(1), p + 2);
        chk("t3_din1", din_at(1), 32'h22);
        chk("t3_din2", din_at(2), 32'h33);
        chk("t3_ss_rises", rises, 1);
        pop_check(8'h11, "t3_rx0", q);
        pop_check(8'h22, "t3_rx1", q);
        pop_check(8'h33, "t3_rx2", q);

        // RX backpressure
        clear_log();
        for (int i = 0; i < 4; i++) push(8'h40 + DW'(i), p);
        do_start(8'd6, t);
        push(8'h44, p);
        push(8'h45, p);
        repeat (60) step();
        chk("t4_stall_wr", wr_cyc.size(), 5);
        chk("t4_stall_busy", bus.busy, 1);
        pop_check(8'h40, "t4_rx0", q);
        repeat (4) step();
        chk("t4_wr_count", wr_cyc.size(), 6);
        chk("t4_sixth_wr", cyc_at(5), q + 3);
        for (int i = 1; i < 6; i++) pop_check(8'h40 + DW'(i), $sformatf("t4_rx%0d", i), q);
        wait_idle("t4_idle");
        for (int i = 0; i < 6; i++) chk($sformatf("t4_din%0d", i), din_at(i), 32'h40 + i);
        chk("t4_ss_rises", rises, 1);

        // Stale done held across the next write
        clr_dly = 3;
        clear_log();
        push(8'hB1, p);
        push(8'hB2, p);
        do_start(8'd2, t);
        wait_idle("t5_idle");
        chk("t5_wr_count", wr_cyc.size(), 2);
        chk("t5_gap", cyc_at(1) - cyc_at(0), WR_GAP);
        pop_check(8'hB1, "t5_rx0", q);
        pop_check(8'hB2, "t5_rx1", q);
        clr_dly = 1;

        // Reset while waiting on the core
        clear_log();
        push(8'hC3, p);
        push(8'hC4, p);
        do_start(8'd1, t);
        d = 0;
        while (wr_cyc.size() == 0 && d < 50) begin
            step();
            d++;
        end
        step();
        chk("t6_busy_before", bus.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_ss_n", bus.ss_n, 1);
        chk("t6_busy", bus.busy, 0);
        chk("t6_rx_valid", bus.rx_valid, 0);
        chk("t6_tx_ready", bus.tx_ready, 1);
        chk("t6_core_wr", bus.core_wr, 0);
        do_start(8'd0, t);
        repeat (10) step();
        chk("t6_len0_busy", bus.busy, 0);
        chk("t6_rx_after", bus.rx_valid, 0);
        clear_log();
        do_start(8'd1, t);
        repeat (10) step();
        chk("t6_tx_discarded", wr_cyc.size(), 0);
        push(8'hD7, p);
        wait_idle("t6_idle");
        chk("t6_new_din", din_at(0), 32'hD7);
        pop_check(8'hD7, "t6_rx", q);

        chk("cs_follows_wr", cs_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
